// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM pipeline stage between EX/MEM and MEM/WB. Handles sized
// loads/stores with byte strobes, misalignment faults, and a ready-based
// data-memory handshake that stalls upstream and aborts after MAX_WAIT cycles.
module mem_stage_hs #(
    parameter int XLEN     = 32,
    parameter int RD_W     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_mem,
    input  logic [4:0]        ctrl_mem,
    input  logic [2:0]        funct3_mem,
    input  logic [RD_W-1:0]   rd_mem,
    input  logic [XLEN-1:0]   pc4_mem,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   write_data1,
    input  logic [XLEN-1:0]   read_data,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_ctrl_input,
    output logic [XLEN-1:0]   address,
    output logic [XLEN-1:0]   w_data,
    output logic [XLEN/8-1:0] w_strb,
    output logic              stall,
    output logic              mem_fault,
    output logic [2:0]        ctrl_wb,
    output logic [RD_W-1:0]   rd_wb,
    output logic [XLEN-1:0]   pc4_wb,
    output logic [XLEN-1:0]   mem_data,
    output logic [XLEN-1:0]   alu_data
);
    localparam int         SW        = XLEN / 8;
    // Value of the wait counter on the last cycle a request may stay unanswered.
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);
    localparam logic [1:0] OP_STORE  = 2'b01;
    localparam logic [1:0] OP_LOAD   = 2'b10;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    // Bundle handed to the WB stage.
    typedef struct packed {
        logic [2:0]      ctrl;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] alu;
    } wb_t;

    // Snapshot of an outstanding memory request, replayed while waiting.
    typedef struct packed {
        logic [1:0]      op;
        logic [2:0]      funct3;
        logic [2:0]      ctrl;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [SW-1:0]   strb;
    } req_t;

    function automatic logic [SW-1:0] store_strb(input logic [1:0] lo, input logic [1:0] size);
        logic [SW-1:0] s;
        case (size)
            2'b00:   s = SW'(1) << lo;
            2'b01:   s = SW'(3) << lo;
            default: s = '1;
        endcase
        return s;
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [XLEN-1:0] wd, input logic [1:0] size);
        logic [XLEN-1:0] d;
        case (size)
            2'b00:   d = {SW{wd[7:0]}};
            2'b01:   d = {(XLEN/16){wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] word, input logic [1:0] lo,
                                                 input logic [2:0] f3);
        logic [XLEN-1:0] b_sh;
        logic [XLEN-1:0] h_sh;
        logic [XLEN-1:0] res;
        b_sh = word >> {lo, 3'b000};
        h_sh = word >> {lo[1], 4'b0000};
        case (f3)
            3'b000:  res = {{(XLEN-8){b_sh[7]}}, b_sh[7:0]};
            3'b001:  res = {{(XLEN-16){h_sh[15]}}, h_sh[15:0]};
            3'b100:  res = {{(XLEN-8){1'b0}}, b_sh[7:0]};
            3'b101:  res = {{(XLEN-16){1'b0}}, h_sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    wb_t        wb_q, wb_d;
    req_t       req_q, req_d;
    logic       fault_q, fault_d;

    logic            req_c, we_c, stall_c;
    logic [1:0]      op_c;
    logic [XLEN-1:0] addr_c, wdata_c;
    logic [SW-1:0]   strb_c;

    logic [1:0] op_in;
    logic       is_st_in, is_ld_in, mem_op_in, misalign_in, start;

    // Decode the incoming instruction and classify its memory access.
    always_comb begin
        op_in       = ctrl_mem[4:3];
        is_st_in    = (op_in == OP_STORE);
        is_ld_in    = (op_in == OP_LOAD);
        mem_op_in   = valid_mem && (is_st_in || is_ld_in);
        misalign_in = mem_op_in &&
                      (((funct3_mem[1:0] == 2'b01) && alu_result[0]) ||
                       (funct3_mem[1] && (alu_result[1:0] != 2'b00)));
        start       = (state_q == S_IDLE) && mem_op_in && !misalign_in;
    end

    // Next-state, handshake outputs and WB bundle for the request FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        wb_d    = wb_q;
        req_d   = req_q;
        fault_d = 1'b0;
        req_c   = 1'b0;
        we_c    = 1'b0;
        stall_c = 1'b0;
        op_c    = op_in;
        addr_c  = {alu_result[XLEN-1:2], 2'b00};
        wdata_c = store_data(write_data1, funct3_mem[1:0]);
        strb_c  = '0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                req_c  = start;
                we_c   = start && is_st_in;
                strb_c = (start && is_st_in) ? store_strb(alu_result[1:0], funct3_mem[1:0]) : '0;
                if (start) begin
                    req_d = '{op: op_in, funct3: funct3_mem, ctrl: ctrl_mem[2:0], rd: rd_mem,
                              pc4: pc4_mem, addr: alu_result, wdata: wdata_c,
                              strb: store_strb(alu_result[1:0], funct3_mem[1:0])};
                end
                if (!mem_op_in) begin
                    wb_d = '{ctrl: valid_mem ? ctrl_mem[2:0] : 3'b000, rd: rd_mem, pc4: pc4_mem,
                             data: '0, alu: alu_result};
                end else if (misalign_in) begin
                    wb_d    = '{ctrl: 3'b000, rd: rd_mem, pc4: pc4_mem, data: '0, alu: alu_result};
                    fault_d = 1'b1;
                end else if (mem_ready) begin
                    wb_d = '{ctrl: ctrl_mem[2:0], rd: rd_mem, pc4: pc4_mem,
                             data: is_ld_in ? load_ext(read_data, alu_result[1:0], funct3_mem) : '0,
                             alu: alu_result};
                end else begin
                    stall_c      = 1'b1;
                    wb_d.ctrl    = 3'b000;
                    if (LAST_WAIT == 8'd0) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 8'd1;
                    end
                end
            end
            S_WAIT: begin
                req_c     = 1'b1;
                we_c      = (req_q.op == OP_STORE);
                op_c      = req_q.op;
                addr_c    = {req_q.addr[XLEN-1:2], 2'b00};
                wdata_c   = req_q.wdata;
                strb_c    = (req_q.op == OP_STORE) ? req_q.strb : '0;
                wb_d.ctrl = 3'b000;
                if (mem_ready) begin
                    wb_d = '{ctrl: req_q.ctrl, rd: req_q.rd, pc4: req_q.pc4,
                             data: (req_q.op == OP_LOAD) ?
                                   load_ext(read_data, req_q.addr[1:0], req_q.funct3) : '0,
                             alu: req_q.addr};
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    stall_c = 1'b1;
                    if (cnt_q >= LAST_WAIT) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        fault_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
        endcase
    end

    // State, request snapshot, fault pulse and WB bundle registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wb_q    <= '0;
            req_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values in parallel.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    // Handshake outputs are forced quiet while reset is held, whatever the inputs.
    assign mem_req        = reset_n && req_c;
    assign mem_we         = reset_n && we_c;
    assign stall          = reset_n && stall_c;
    assign w_strb         = reset_n ? strb_c : '0;
    assign mem_ctrl_input = op_c;
    assign address        = addr_c;
    assign w_data         = wdata_c;
    assign mem_fault      = fault_q;
    assign ctrl_wb        = wb_q.ctrl;
    assign rd_wb          = wb_q.rd;
    assign pc4_wb         = wb_q.pc4;
    assign mem_data       = wb_q.data;
    assign alu_data       = wb_q.alu;
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed stimulus with a scoreboard; the monitor pops an
// expected WB bundle whenever the stage retires an instruction or faults.
module tb_mem_stage_hs;
    logic        clk;
    logic        reset_n;
    logic        valid_mem;
    logic [4:0]  ctrl_mem;
    logic [2:0]  funct3_mem;
    logic [31:0] rd_mem, pc4_mem, alu_result, write_data1, read_data;
    logic        mem_ready;
    logic        mem_req, mem_we, stall, mem_fault;
    logic [1:0]  mem_ctrl_input;
    logic [31:0] address, w_data;
    logic [3:0]  w_strb;
    logic [2:0]  ctrl_wb;
    logic [31:0] rd_wb, pc4_wb, mem_data, alu_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] rd;
        logic [31:0] pc4;
        logic [31:0] md;
        logic [31:0] alu;
        logic        fault;
        logic        full;
    } exp_t;

    exp_t sb[$];

    mem_stage_hs #(.XLEN(32), .RD_W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .reset_n(reset_n), .valid_mem(valid_mem), .ctrl_mem(ctrl_mem),
        .funct3_mem(funct3_mem), .rd_mem(rd_mem), .pc4_mem(pc4_mem), .alu_result(alu_result),
        .write_data1(write_data1), .read_data(read_data), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ctrl_input(mem_ctrl_input), .address(address),
        .w_data(w_data), .w_strb(w_strb), .stall(stall), .mem_fault(mem_fault),
        .ctrl_wb(ctrl_wb), .rd_wb(rd_wb), .pc4_wb(pc4_wb), .mem_data(mem_data), .alu_data(alu_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] c, input logic [2:0] f3,
                         input logic [31:0] rd, input logic [31:0] pc4, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] rdata, input logic rdy);
        valid_mem   = v;
        ctrl_mem    = c;
        funct3_mem  = f3;
        rd_mem      = rd;
        pc4_mem     = pc4;
        alu_result  = alu;
        write_data1 = wd;
        read_data   = rdata;
        mem_ready   = rdy;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 5'b00000, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, rdy);
    endtask

    task automatic push(input logic [2:0] c, input logic [31:0] rd, input logic [31:0] pc4,
                        input logic [31:0] md, input logic [31:0] alu, input logic f,
                        input logic full);
        exp_t e;
        e = '{ctrl: c, rd: rd, pc4: pc4, md: md, alu: alu, fault: f, full: full};
        sb.push_back(e);
    endtask

    // Monitor: every retirement (nonzero ctrl_wb) or fault pulse consumes one expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && (ctrl_wb != 3'b000 || mem_fault)) begin
                check("sb_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("wb_ctrl", 32'(ctrl_wb), 32'(e.ctrl));
                    check("wb_fault", 32'(mem_fault), 32'(e.fault));
                    if (e.full) begin
                        check("wb_rd", rd_wb, e.rd);
                        check("wb_pc4", pc4_wb, e.pc4);
                        check("wb_mem_data", mem_data, e.md);
                        check("wb_alu", alu_data, e.alu);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;

        // Reset state with non-zero upstream values present.
        reset_n = 1'b0;
        drive(1'b0, 5'b00000, 3'b000, 32'd12, 32'd72, 32'd40, 32'd0, 32'd0, 1'b0);
        #2;
        check("rst_ctrl_wb", 32'(ctrl_wb), 32'd0);
        check("rst_rd_wb", rd_wb, 32'd0);
        check("rst_pc4_wb", pc4_wb, 32'd0);
        check("rst_alu_data", alu_data, 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_w_strb", 32'(w_strb), 32'd0);
        step();
        step();

        // Store word with immediate ready.
        reset_n = 1'b1;
        drive(1'b1, 5'b01111, 3'b010, 32'd12, 32'd72, 32'd48, 32'd40, 32'd0, 1'b1);
        push(3'b111, 32'd12, 32'd72, 32'd0, 32'd48, 1'b0, 1'b1);
        #1;
        check("sw_mem_req", 32'(mem_req), 32'd1);
        check("sw_mem_we", 32'(mem_we), 32'd1);
        check("sw_w_strb", 32'(w_strb), 32'hF);
        check("sw_w_data", w_data, 32'd40);
        check("sw_address", address, 32'd48);
        check("sw_stall", 32'(stall), 32'd0);
        step();

        // Sized loads with immediate ready: byte/half, signed/unsigned, all lanes.
        drive(1'b1, 5'b10110, 3'b000, 32'd5, 32'd100, 32'h45, 32'd0, 32'h0080FF00, 1'b1);
        push(3'b110, 32'd5, 32'd100, 32'hFFFFFFFF, 32'h45, 1'b0, 1'b1);
        #1;
        check("lb_address", address, 32'h44);
        check("lb_mem_we", 32'(mem_we), 32'd0);
        check("lb_ctrl_in", 32'(mem_ctrl_input), 32'd2);
        step();
        drive(1'b1, 5'b10110, 3'b100, 32'd6, 32'd104, 32'h45, 32'd0, 32'h0080FF00, 1'b1);
        push(3'b110, 32'd6, 32'd104, 32'h000000FF, 32'h45, 1'b0, 1'b1);
        step();
        drive(1'b1, 5'b10110, 3'b001, 32'd7, 32'd108, 32'h42, 32'd0, 32'h80011234, 1'b1);
        push(3'b110, 32'd7, 32'd108, 32'hFFFF8001, 32'h42, 1'b0, 1'b1);
        step();
        drive(1'b1, 5'b10110, 3'b101, 32'd8, 32'd112, 32'h40, 32'd0, 32'h80011234, 1'b1);
        push(3'b110, 32'd8, 32'd112, 32'h00001234, 32'h40, 1'b0, 1'b1);
        step();
        drive(1'b1, 5'b10010, 3'b000, 32'd9, 32'd116, 32'h43, 32'd0, 32'h7F000000, 1'b1);
        push(3'b010, 32'd9, 32'd116, 32'h0000007F, 32'h43, 1'b0, 1'b1);
        step();
        drive(1'b1, 5'b10010, 3'b010, 32'd10, 32'd120, 32'h48, 32'd0, 32'hDEADBEEF, 1'b1);
        push(3'b010, 32'd10, 32'd120, 32'hDEADBEEF, 32'h48, 1'b0, 1'b1);
        step();
        idle(1'b0);
        step();

        // Load word with three unanswered cycles; upstream changes are ignored.
        drive(1'b1, 5'b10011, 3'b010, 32'd7, 32'd200, 32'h40, 32'd0, 32'd0, 1'b0);
        push(3'b011, 32'd7, 32'd200, 32'd320, 32'h40, 1'b0, 1'b1);
        #1;
        check("wt_req_c0", 32'(mem_req), 32'd1);
        check("wt_stall_c0", 32'(stall), 32'd1);
        for (int i = 1; i <= 2; i++) begin
            step();
            drive(1'b0, 5'b00000, 3'b000, 32'd0, 32'd0, 32'h99, 32'd0, 32'd0, 1'b0);
            #1;
            check("wt_stall", 32'(stall), 32'd1);
            check("wt_req", 32'(mem_req), 32'd1);
            check("wt_address", address, 32'h40);
            check("wt_ctrl_wb", 32'(ctrl_wb), 32'd0);
            check("wt_alu_hold", alu_data, 32'd0);
        end
        step();
        drive(1'b0, 5'b00000, 3'b000, 32'd0, 32'd0, 32'h99, 32'd0, 32'd320, 1'b1);
        #1;
        check("wt_stall_ready", 32'(stall), 32'd0);
        check("wt_req_ready", 32'(mem_req), 32'd1);
        step();
        idle(1'b0);
        step();

        // Misaligned half store and word load: bubble plus fault, no request.
        drive(1'b1, 5'b01101, 3'b001, 32'd2, 32'd300, 32'h41, 32'h1234, 32'd0, 1'b1);
        push(3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        #1;
        check("mis_sh_req", 32'(mem_req), 32'd0);
        check("mis_sh_strb", 32'(w_strb), 32'd0);
        step();
        drive(1'b1, 5'b10101, 3'b010, 32'd2, 32'd304, 32'h46, 32'd0, 32'd0, 1'b1);
        push(3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        #1;
        check("mis_lw_req", 32'(mem_req), 32'd0);
        step();

        // Sub-word stores: strobes and lane replication.
        drive(1'b1, 5'b01101, 3'b000, 32'd2, 32'd400, 32'h43, 32'hAB, 32'd0, 1'b1);
        push(3'b101, 32'd2, 32'd400, 32'd0, 32'h43, 1'b0, 1'b1);
        #1;
        check("sb_strb", 32'(w_strb), 32'b1000);
        check("sb_wdata", w_data, 32'hABABABAB);
        check("sb_address", address, 32'h40);
        step();
        drive(1'b1, 5'b01101, 3'b001, 32'd2, 32'd404, 32'h42, 32'h1234BEEF, 32'd0, 1'b1);
        push(3'b101, 32'd2, 32'd404, 32'd0, 32'h42, 1'b0, 1'b1);
        #1;
        check("sh_strb", 32'(w_strb), 32'b1100);
        check("sh_wdata", w_data, 32'hBEEFBEEF);
        step();
        drive(1'b1, 5'b01101, 3'b000, 32'd2, 32'd408, 32'h40, 32'h55, 32'd0, 1'b1);
        push(3'b101, 32'd2, 32'd408, 32'd0, 32'h40, 1'b0, 1'b1);
        #1;
        check("sb0_strb", 32'(w_strb), 32'b0001);
        check("sb0_wdata", w_data, 32'h55555555);
        step();
        idle(1'b0);
        step();

        // Timeout: mem_ready never arrives.
        drive(1'b1, 5'b10010, 3'b010, 32'd4, 32'd500, 32'h50, 32'd0, 32'd0, 1'b0);
        push(3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        #1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!stall) break;
            n++;
            step();
            idle(1'b0);
            #1;
        end
        check("to_stall_cycles", n, 32'd15);
        check("to_stall_low", 32'(stall), 32'd0);
        check("to_req_low", 32'(mem_req), 32'd0);
        check("to_fault", 32'(mem_fault), 32'd1);
        step();
        idle(1'b0);
        step();

        // Reset in the middle of a wait: everything clears at once.
        drive(1'b1, 5'b00110, 3'b000, 32'd9, 32'd300, 32'h77, 32'd0, 32'd0, 1'b0);
        push(3'b110, 32'd9, 32'd300, 32'd0, 32'h77, 1'b0, 1'b1);
        step();
        drive(1'b1, 5'b10111, 3'b010, 32'd11, 32'd600, 32'h60, 32'd0, 32'd0, 1'b0);
        step();
        idle(1'b0);
        #1;
        check("rw_pc4_hold", pc4_wb, 32'd300);
        check("rw_stall", 32'(stall), 32'd1);
        step();
        reset_n = 1'b0;
        #1;
        check("rw_mem_req", 32'(mem_req), 32'd0);
        check("rw_stall_rst", 32'(stall), 32'd0);
        check("rw_ctrl_wb", 32'(ctrl_wb), 32'd0);
        check("rw_rd_wb", rd_wb, 32'd0);
        check("rw_pc4_wb", pc4_wb, 32'd0);
        check("rw_alu_data", alu_data, 32'd0);
        step();
        reset_n = 1'b1;
        drive(1'b1, 5'b00101, 3'b000, 32'd3, 32'd52, 32'h10, 32'd0, 32'd0, 1'b1);
        push(3'b101, 32'd3, 32'd52, 32'd0, 32'h10, 1'b0, 1'b1);
        #1;
        check("np_mem_req", 32'(mem_req), 32'd0);
        check("np_stall", 32'(stall), 32'd0);
        step();
        idle(1'b1);
        repeat (4) step();

        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Parametrised successor to the 32-bit MEM pipeline stage. Sits between EX/MEM and MEM/WB.
- Adds sized loads/stores (byte/half/word), sign/zero extension and byte strobes.
- Adds misalignment detection and a ready-based data-memory handshake with stall generation and a bounded wait timeout.
- Registers the WB-side bundle as before: ctrl_wb, rd_wb, pc4_wb, mem_data, alu_data.

Parameters:
XLEN, 32, datapath/address width; multiple of 8; 32 is the only verified value.
RD_W, 32, width of rd_mem/rd_wb.
MAX_WAIT, 15, max cycles mem_req may stay unanswered before abort; 1..255.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
valid_mem  in  1  instruction in MEM is valid.
ctrl_mem  in  5  [4:3] mem op (01 store, 10 load, 00/11 none); [2:0] WB control.
funct3_mem  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; stores use [1:0].
rd_mem  in  RD_W  destination.
pc4_mem  in  XLEN  PC+4.
alu_result  in  XLEN  effective address / ALU value.
write_data1  in  XLEN  store source.
read_data  in  XLEN  memory read word.
mem_ready  in  1  memory completes current request this cycle.
mem_req  out  1  request valid.
mem_we  out  1  1 = store.
mem_ctrl_input  out  2  mem op of active request (ctrl_mem[4:3], or latched copy in WAIT).
address  out  XLEN  word-aligned address (low 2 bits forced 0).
w_data  out  XLEN  store data replicated into lanes.
w_strb  out  XLEN/8  byte enables.
stall  out  1  hold IF..MEM inputs this cycle.
mem_fault  out  1  one-cycle pulse: misalign or timeout.
ctrl_wb  out  3  registered WB control.
rd_wb  out  RD_W  registered rd.
pc4_wb  out  XLEN  registered PC+4.
mem_data  out  XLEN  registered extended load data.
alu_data  out  XLEN  registered ALU result.

Behaviour:
- Reset (async, any state): FSM → IDLE, wait counter 0.
  - All registered outputs are 0.
  - mem_req, mem_we, stall, w_strb are 0.
  - A request aborted by reset is never completed.
- FSM state IDLE, no memory op (valid_mem=0 or op 00/11): no request. WB regs capture the inputs next edge; mem_data ← 0; ctrl_wb ← 0 if !valid_mem.
- Misaligned access: H with addr[0]=1, or W with addr[1:0]≠0.
  - No request is issued.
  - Next edge: ctrl_wb ← 0 (bubble), mem_fault=1 for one cycle.
- FSM state IDLE, aligned load/store:
  - mem_req=1 combinationally in the same cycle.
  - Address, data, strobe, op, funct3, rd, pc4 and alu are latched at the edge.
  - If mem_ready=1 in the same cycle: complete, zero wait; WB regs update at that edge; stall=0.
  - Else: go to WAIT with stall=1.
- FSM state WAIT:
  - Memory outputs are driven from latched values; mem_req=1, stall=1, ctrl_wb register ← 0 (bubble each cycle).
  - mem_ready=1: stall=0 that cycle; WB regs load latched values plus extended read_data; → IDLE.
  - Counter reaches MAX_WAIT without mem_ready: → IDLE, mem_fault pulse, ctrl_wb ← 0, stall drops.
- Load extraction: lane = addr[1:0] (byte) or addr[1] (half).
  - B/H sign-extend; BU/HU zero-extend; W passes the word.
  - Stores load mem_data ← 0.
- Store: w_strb = 0001<<addr[1:0] (B), 0011<<addr[1:0] (H), 1111 (W).
  - w_data = byte/half replicated across all lanes.
- Latency: 1 cycle with zero wait; 1+N cycles for N wait cycles. WB regs hold their value (except ctrl_wb) while stalled.
- Simultaneous events:
  - mem_ready on the timeout cycle counts as completion.
  - valid_mem changes during WAIT are ignored, because upstream is stalled.

Test Plan:
- Reset low, inputs pc4=72, alu=40, rd=12 → all WB outputs 0, mem_req=0; release with ctrl_mem=01111, funct3=010, alu=48, wd=40, mem_ready=1 → same-cycle mem_req=1, mem_we=1, w_strb=1111, w_data=40, no stall; next edge ctrl_wb=111, alu_data=48, mem_data=0.
- Load byte: ctrl_mem=10110, funct3=000, alu=0x45, read_data=0x0080FF00, ready=1 → address=0x44, mem_data=0xFFFFFFFF, ctrl_wb=110; repeat with funct3=100 → 0x000000FF.
- Wait states: load word at 0x40, mem_ready low 3 cycles then high with read_data=320 → stall high 3 cycles, ctrl_wb=0 during stall, mem_data=320 one edge after ready.
- Misalign: SH at alu=0x41 → mem_req never asserted, mem_fault one-cycle pulse, ctrl_wb=0; SB at 0x43, wd=0xAB → w_strb=1000, w_data=0xABABABAB.
- Timeout: load with mem_ready held low → stall for MAX_WAIT cycles, then mem_fault pulse, stall=0, FSM back in IDLE.
- Reset mid-WAIT: assert reset_n=0 on wait cycle 2 → mem_req, stall and all WB outputs 0 immediately; after release, a non-mem op (ctrl_mem=00101, pc4=52) passes in 1 cycle with ctrl_wb=101.
